// File: rtl/mlp_param_loader_pkg.sv
// Shared types and stream-length helpers for the MLP parameter loader.
package mlp_param_loader_pkg;

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_B, LOAD_X, ISSUE} state_t;

  function automatic int nw_count(input int m, input int n);
    return (m - 1) * n * n;
  endfunction

  function automatic int nb_count(input int m, input int n);
    return (m - 1) * n;
  endfunction

  // The weight segment is always the longest, so it sizes the shared counter.
  function automatic int cnt_width(input int m, input int n);
    return $clog2(nw_count(m, n) + 1);
  endfunction

endpackage

// File: rtl/mlp_param_loader_ctrl.sv
// Load sequencer: walks W -> B -> X segments with one shared element counter.
module mlp_load_ctrl
  import mlp_param_loader_pkg::*;
#(
  parameter int M  = 2,
  parameter int N  = 2,
  parameter int CW = cnt_width(M, N)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start_full,
  input  logic          start_x,
  input  logic          in_valid,
  output state_t        state,
  output logic [CW-1:0] cnt,
  output logic          in_ready,
  output logic          accept,
  output logic          init,
  output logic          initial_flag,
  output logic          weight_flag,
  output logic          busy,
  output logic          err
);

  localparam int NW = nw_count(M, N);
  localparam int NB = nb_count(M, N);
  localparam logic [CW-1:0] LAST_W = CW'(NW - 1);
  localparam logic [CW-1:0] LAST_B = CW'(NB - 1);
  localparam logic [CW-1:0] LAST_X = CW'(N - 1);

  state_t        state_n;
  logic [CW-1:0] cnt_n;
  logic          wflag_n, pend_n, err_n, pending;

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state       <= IDLE;
      cnt         <= '0;
      weight_flag <= 1'b0;
      pending     <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      weight_flag <= wflag_n;
      pending     <= pend_n;
      err         <= err_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    wflag_n      = weight_flag;
    pend_n       = pending;
    err_n        = err;
    in_ready     = 1'b0;
    init         = 1'b0;
    initial_flag = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (start_full) begin
          state_n = LOAD_W;
          cnt_n   = '0;
          wflag_n = 1'b0;
        end else if (start_x) begin
          if (weight_flag) begin
            state_n = LOAD_X;
            cnt_n   = '0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      LOAD_W: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (cnt == LAST_W) begin
            state_n = LOAD_B;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (cnt == LAST_B) begin
            state_n = LOAD_X;
            cnt_n   = '0;
            wflag_n = 1'b1;
            pend_n  = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      LOAD_X: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (cnt == LAST_X) begin
            state_n = ISSUE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      ISSUE: begin
        init         = 1'b1;
        initial_flag = pending;
        pend_n       = 1'b0;
        state_n      = IDLE;
        cnt_n        = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign accept = in_valid & in_ready;

endmodule

// File: rtl/mlp_param_loader.sv
// Streams MLP weights, biases and inputs into registered arrays, then fires init.
module mlp_param_loader
  import mlp_param_loader_pkg::*;
#(
  parameter int M  = 2,
  parameter int N  = 2,
  parameter int QM = 3,
  parameter int QN = 5,
  parameter int WM = 3,
  parameter int WN = 5
) (
  input  logic                                  clk,
  input  logic                                  nrst,
  input  logic                                  start_full,
  input  logic                                  start_x,
  input  logic                                  in_valid,
  input  logic [QM+QN-1:0]                      in_data,
  output logic                                  in_ready,
  output logic [N-1:0][QM+QN-1:0]               x,
  output logic [M-2:0][N-1:0][N-1:0][QM+QN-1:0] w,
  output logic [M-2:0][N-1:0][QM+QN-1:0]        b,
  output logic                                  init,
  output logic                                  initial_flag,
  output logic                                  weight_flag,
  output logic                                  busy,
  output logic                                  err
);

  localparam int QW = QM + QN;
  localparam int WW = WM + WN;
  localparam int CW = cnt_width(M, N);

  if (WW > QW) begin : g_width_chk
    $error("weight word wider than data word");
  end

  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic [QW-1:0] w_word;

  // Weights travel in the low WW bits of the stream word.
  assign w_word = QW'($signed(in_data[WW-1:0]));

  mlp_load_ctrl #(.M(M), .N(N), .CW(CW)) u_ctrl (
    .clk          (clk),
    .nrst         (nrst),
    .start_full   (start_full),
    .start_x      (start_x),
    .in_valid     (in_valid),
    .state        (state),
    .cnt          (cnt),
    .in_ready     (in_ready),
    .accept       (accept),
    .init         (init),
    .initial_flag (initial_flag),
    .weight_flag  (weight_flag),
    .busy         (busy),
    .err          (err)
  );

  // Counter value is the flat index within the current segment.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      x <= '0;
      w <= '0;
      b <= '0;
    end else if (accept) begin
      for (int l = 0; l < M - 1; l++) begin
        for (int n = 0; n < N; n++) begin
          if (state == LOAD_B && int'(cnt) == l * N + n) b[l][n] <= in_data;
          for (int i = 0; i < N; i++)
            if (state == LOAD_W && int'(cnt) == (l * N + n) * N + i) w[l][n][i] <= w_word;
        end
      end
      for (int i = 0; i < N; i++)
        if (state == LOAD_X && int'(cnt) == i) x[i] <= in_data;
    end
  end

endmodule
